// File: rtl/muhux_pkg.sv
// ============================================================================
//  Module      : muhux_pkg
//  Description : Shared constants, FSM encoding and round-robin pick helper
//                for the muhux round-robin mux scheduler.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package muhux_pkg;

    // Requester count and mux select width
    localparam int SEL_W = 2;
    localparam int N_REQ = 4;

    // FSM encoding
    localparam logic [0:0] c_ST_IDLE  = 1'b0;
    localparam logic [0:0] c_ST_GRANT = 1'b1;

    // Pick the first asserted request scanning ptr, ptr+1, ... modulo N_REQ.
    // Returns ptr when nothing is asserted; callers qualify with |req.
    function automatic logic [SEL_W-1:0] rr_pick(
        input logic [N_REQ-1:0] req,
        input logic [SEL_W-1:0] ptr
    );
        logic [SEL_W-1:0] idx;
        logic             found;
        rr_pick = ptr;
        found   = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            idx = ptr + SEL_W'(i);
            if (!found && req[idx]) begin
                rr_pick = idx;
                found   = 1'b1;
            end
        end
    endfunction

endpackage

`default_nettype wire

// File: rtl/muhux_mux4.sv
// ============================================================================
//  Module      : muhux_mux4
//  Description : Combinational 4:1 single-bit multiplexer.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module muhux_mux4
    import muhux_pkg::*;
(
    input  logic [N_REQ-1:0] i_d,
    input  logic [SEL_W-1:0] i_sel,
    output logic             o_y
);

    // Select one data bit
    assign o_y = i_d[i_sel];

endmodule

`default_nettype wire

// File: rtl/tt_um_muhux_rr_sched.sv
// ============================================================================
//  Module      : tt_um_muhux_rr_sched
//  Description : Round-robin scheduler time-sharing one 4:1 bit mux among four
//                requesters, with a programmable per-grant dwell and a
//                registered mux output. TinyTapeout tile top level.
//  Config      : define MUHUX_REQSYNC_EN to pass req[3:0] through a 2-flop
//                synchronizer ahead of the FSM (+2 cycles request latency).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tt_um_muhux_rr_sched
    import muhux_pkg::*;
#(
    parameter int DWELL_DEFAULT = 4,
    parameter int CNT_W         = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uo_out,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    // ------------------------------------------------------------------
    // Input decode
    // ------------------------------------------------------------------
    logic [N_REQ-1:0] w_d;
    logic [N_REQ-1:0] w_req_raw;
    logic [N_REQ-1:0] w_req;
    logic             w_cfg_we;
    logic [CNT_W-1:0] w_cfg_dwell;
    logic             w_unused;

    assign w_d         = ui_in[3:0];
    assign w_req_raw   = ui_in[7:4];
    assign w_cfg_we    = uio_in[4];
    assign w_cfg_dwell = CNT_W'(uio_in[3:0]);

    // The tile enable and upper uio bits carry no function
    assign w_unused = &{1'b0, ena, uio_in[7:5]};

`ifdef MUHUX_REQSYNC_EN
    logic [N_REQ-1:0] r_req_s1;
    logic [N_REQ-1:0] r_req_s2;

    // Two-flop request synchronizer; data bits are deliberately left raw
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_req_s1 <= '0;
            r_req_s2 <= '0;
        end else begin
            r_req_s1 <= w_req_raw;
            r_req_s2 <= r_req_s1;
        end
    end

    assign w_req = r_req_s2;
`else
    assign w_req = w_req_raw;
`endif

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [0:0]       r_state;
    logic [SEL_W-1:0] r_sel;
    logic [SEL_W-1:0] r_ptr;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_dwell;
    logic [N_REQ-1:0] r_gnt;
    logic             r_busy;
    logic             r_dout;

    logic [0:0]       w_state_nx;
    logic [SEL_W-1:0] w_sel_nx;
    logic [SEL_W-1:0] w_ptr_nx;
    logic [CNT_W-1:0] w_cnt_nx;
    logic             w_busy_nx;
    logic [N_REQ-1:0] w_gnt_nx;
    logic             w_mux_y;

    logic             w_end;
    logic             w_arb;
    logic [SEL_W-1:0] w_scan_ptr;
    logic [SEL_W-1:0] w_pick;
    logic [CNT_W-1:0] w_cnt_load;

    // A grant ends on dwell expiry or when its owner drops the request;
    // both cases are handled the same way.
    assign w_end = (r_state == c_ST_GRANT) && ((r_cnt == '0) || !w_req[r_sel]);
    assign w_arb = (r_state == c_ST_IDLE) || w_end;

    // On a grant end the scan starts just past the outgoing owner so that
    // the owner is considered last (and is re-granted if alone).
    assign w_scan_ptr = w_end ? (r_sel + SEL_W'(1)) : r_ptr;
    assign w_pick     = rr_pick(w_req, w_scan_ptr);

    // Dwell 0 behaves as 1
    assign w_cnt_load = (r_dwell == '0) ? '0 : (r_dwell - CNT_W'(1));

    // Next-state / arbitration logic
    always_comb begin
        w_state_nx = r_state;
        w_sel_nx   = r_sel;
        w_ptr_nx   = r_ptr;
        w_cnt_nx   = r_cnt;
        w_busy_nx  = r_busy;

        if (w_end) begin
            w_ptr_nx = r_sel + SEL_W'(1);
        end

        if (w_arb) begin
            if (|w_req) begin
                w_state_nx = c_ST_GRANT;
                w_sel_nx   = w_pick;
                w_cnt_nx   = w_cnt_load;
                w_busy_nx  = 1'b1;
            end else begin
                w_state_nx = c_ST_IDLE;
                w_sel_nx   = '0;
                w_cnt_nx   = '0;
                w_busy_nx  = 1'b0;
            end
        end else begin
            w_cnt_nx = r_cnt - CNT_W'(1);
        end
    end

    assign w_gnt_nx = w_busy_nx ? (N_REQ'(1) << w_sel_nx) : '0;

    // The mux looks at the next select so dout lands on the same edge as gnt/sel
    muhux_mux4 u_mux (
        .i_d   (w_d),
        .i_sel (w_sel_nx),
        .o_y   (w_mux_y)
    );

    // FSM, pointer, counter and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_ST_IDLE;
            r_sel   <= '0;
            r_ptr   <= '0;
            r_cnt   <= '0;
            r_gnt   <= '0;
            r_busy  <= 1'b0;
            r_dout  <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_sel   <= w_sel_nx;
            r_ptr   <= w_ptr_nx;
            r_cnt   <= w_cnt_nx;
            r_gnt   <= w_gnt_nx;
            r_busy  <= w_busy_nx;
            r_dout  <= w_busy_nx ? w_mux_y : 1'b0;
        end
    end

    // Dwell register; a new value only applies at the next grant entry
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dwell <= CNT_W'(DWELL_DEFAULT);
        end else if (w_cfg_we) begin
            r_dwell <= w_cfg_dwell;
        end
    end

    assign uo_out  = {r_busy, r_gnt, r_sel, r_dout};
    assign uio_out = 8'h00;
    assign uio_oe  = 8'h00;

endmodule

`default_nettype wire
